// File: rtl/spi_req_arbiter_if.sv
// Bundle between the requesters / SPI byte engine and spi_req_arbiter.
//   slave  : arbiter view (takes requests and master results, drives grants, responses, start)
//   master : environment view (requesters plus the SPI master byte engine)
// Signals:
//   req, req_data          requester levels and per-requester TX bytes (slice i = [i*DATA_W +: DATA_W])
//   ack, rsp_valid         one-hot single-cycle pulses back to the requesters
//   rsp_data, rsp_err      response byte and timeout flag, qualified by rsp_valid
//   busy, gnt_id           arbiter status
//   spi_start, spi_tx_data command to the SPI master
//   spi_done, spi_rx_data  completion from the SPI master
interface spi_req_arbiter_if #(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned DATA_W = 8
);
    localparam int unsigned IDX_W = $clog2(N_REQ);

    logic [N_REQ-1:0]        req;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        ack;
    logic [N_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]       rsp_data;
    logic                    rsp_err;
    logic                    busy;
    logic [IDX_W-1:0]        gnt_id;
    logic                    spi_start;
    logic [DATA_W-1:0]       spi_tx_data;
    logic                    spi_done;
    logic [DATA_W-1:0]       spi_rx_data;

    modport slave (
        input  req, req_data, spi_done, spi_rx_data,
        output ack, rsp_valid, rsp_data, rsp_err, busy, gnt_id, spi_start, spi_tx_data
    );

    modport master (
        output req, req_data, spi_done, spi_rx_data,
        input  ack, rsp_valid, rsp_data, rsp_err, busy, gnt_id, spi_start, spi_tx_data
    );
endinterface

// File: rtl/spi_req_arbiter.sv
// Round-robin arbiter sharing one SPI master byte engine between N_REQ requesters.
// A granted requester's TX byte is latched, the master is started, and the RX byte
// (or a timeout error) is returned to that requester. All outputs are registered.
// Ports:
//   clk    system clock
//   reset  asynchronous, active-low reset
//   bus    spi_req_arbiter_if slave modport (requests, responses, SPI master handshake)
module spi_req_arbiter #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned TIMEOUT = 64
) (
    input logic               clk,
    input logic               reset,
    spi_req_arbiter_if.slave  bus
);
    localparam int unsigned IDX_W = $clog2(N_REQ);
    localparam int unsigned TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  last_q, last_d;
    logic [IDX_W-1:0]  gnt_q, gnt_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic [N_REQ-1:0]  ack_q, ack_d;
    logic [N_REQ-1:0]  rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_err_q, rsp_err_d;
    logic              busy_q, busy_d;
    logic              start_q, start_d;
    logic [DATA_W-1:0] tx_q, tx_d;

    logic              found;
    logic [IDX_W-1:0]  pick;
    logic [IDX_W-1:0]  cand;
    logic              timeout_hit;

    // Search starts just after the last served requester and wraps once around.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int k = 1; k <= int'(N_REQ); k++) begin
            cand = IDX_W'((int'(last_q) + k) % int'(N_REQ));
            if (!found && bus.req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    assign timeout_hit = (TIMEOUT != 0) && (tmr_q == TMR_W'(TIMEOUT - 1));

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        gnt_d       = gnt_q;
        tmr_d       = tmr_q;
        tx_d        = tx_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        ack_d       = '0;
        rsp_valid_d = '0;
        start_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (found) begin
                    gnt_d   = pick;
                    tx_d    = bus.req_data[pick*DATA_W +: DATA_W];
                    ack_d   = N_REQ'(1) << pick;
                    start_d = 1'b1;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                tmr_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                // A done on the timeout cycle still counts as a good transfer.
                if (bus.spi_done) begin
                    rsp_data_d  = bus.spi_rx_data;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = N_REQ'(1) << gnt_q;
                    state_d     = StResp;
                end else if (timeout_hit) begin
                    rsp_data_d  = '0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = N_REQ'(1) << gnt_q;
                    state_d     = StResp;
                end else if (TIMEOUT != 0) begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            StResp: begin
                last_d  = gnt_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            last_q      <= IDX_W'(N_REQ - 1);
            gnt_q       <= '0;
            tmr_q       <= '0;
            tx_q        <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            ack_q       <= '0;
            rsp_valid_q <= '0;
            busy_q      <= 1'b0;
            start_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            gnt_q       <= gnt_d;
            tmr_q       <= tmr_d;
            tx_q        <= tx_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            ack_q       <= ack_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
            start_q     <= start_d;
        end
    end

    assign bus.ack         = ack_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_data    = rsp_data_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.busy        = busy_q;
    assign bus.gnt_id      = gnt_q;
    assign bus.spi_start   = start_q;
    assign bus.spi_tx_data = tx_q;
endmodule

// File: tb/tb_spi_req_arbiter.sv
module tb_spi_req_arbiter;
    localparam int unsigned NReq    = 4;
    localparam int unsigned DataW   = 8;
    localparam int unsigned Timeout = 64;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    spi_req_arbiter_if #(.N_REQ(NReq), .DATA_W(DataW)) bus ();

    spi_req_arbiter #(
        .N_REQ   (NReq),
        .DATA_W  (DataW),
        .TIMEOUT (Timeout)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int n_starts = 0;

    always @(negedge clk) if (bus.spi_start) n_starts++;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Returns at the negedge of the ISSUE cycle, or after a bounded number of cycles.
    task automatic wait_ack();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.ack != '0) break;
        end
    endtask

    // One full transaction for requester g: ack/start checks, done after `delay` cycles.
    task automatic serve(input int g, input logic [7:0] tx, input logic [7:0] rx, input int delay);
        wait_ack();
        check_eq($sformatf("ack_g%0d", g), 32'(bus.ack), 32'(4'b1 << g));
        check_eq($sformatf("start_g%0d", g), 32'(bus.spi_start), 32'd1);
        check_eq($sformatf("gnt_g%0d", g), 32'(bus.gnt_id), 32'(g));
        check_eq($sformatf("tx_g%0d", g), 32'(bus.spi_tx_data), 32'(tx));
        bus.req[g] = 1'b0;
        @(negedge clk);
        check_eq($sformatf("ack_off_g%0d", g), 32'({bus.ack, bus.spi_start}), 32'd0);
        repeat (delay - 1) @(negedge clk);
        bus.spi_done    = 1'b1;
        bus.spi_rx_data = rx;
        @(negedge clk);
        bus.spi_done    = 1'b0;
        bus.spi_rx_data = 8'hEE;
        check_eq($sformatf("rspv_g%0d", g), 32'(bus.rsp_valid), 32'(4'b1 << g));
        check_eq($sformatf("rspd_g%0d", g), 32'(bus.rsp_data), 32'(rx));
        check_eq($sformatf("rspe_g%0d", g), 32'(bus.rsp_err), 32'd0);
        @(negedge clk);
        check_eq($sformatf("idle_g%0d", g), 32'({bus.rsp_valid, bus.busy}), 32'd0);
    endtask

    task automatic apply_reset();
        reset           = 1'b0;
        bus.req         = '0;
        bus.spi_done    = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int s0;
        logic [3:0] seen;
        bus.req         = '0;
        bus.req_data    = '0;
        bus.spi_done    = 1'b0;
        bus.spi_rx_data = '0;

        // Reset state.
        repeat (2) @(negedge clk);
        check_eq("rst_ack", 32'(bus.ack), 32'd0);
        check_eq("rst_rspv", 32'(bus.rsp_valid), 32'd0);
        check_eq("rst_misc", 32'({bus.rsp_data, bus.rsp_err, bus.busy, bus.spi_start}), 32'd0);
        check_eq("rst_tx_gnt", 32'({bus.spi_tx_data, bus.gnt_id}), 32'd0);
        reset = 1'b1;

        // Single request from requester 2.
        @(negedge clk);
        bus.req_data = {8'h00, 8'hA5, 8'h00, 8'h00};
        bus.req      = 4'b0100;
        serve(2, 8'hA5, 8'h3C, 20);

        // All four at once from reset: 0,1,2,3.
        apply_reset();
        bus.req_data = {8'h13, 8'h12, 8'h11, 8'h10};
        bus.req      = 4'b1111;
        s0 = n_starts;
        for (int g = 0; g < 4; g++) serve(g, 8'h10 + 8'(g), 8'h80 + 8'(g), 3);
        check_eq("start_count", 32'(n_starts - s0), 32'd4);

        // Fairness: after 2, req 1010 -> 3 then 1; 1 held high never beats pending 3.
        bus.req = 4'b0100;
        serve(2, 8'h12, 8'h21, 2);
        bus.req = 4'b1010;
        serve(3, 8'h13, 8'h31, 2);
        serve(1, 8'h11, 8'h41, 2);
        bus.req = 4'b1010;
        serve(3, 8'h13, 8'h32, 2);
        serve(1, 8'h11, 8'h42, 2);

        // Timeout: no done, rsp_valid 64 cycles after WAIT entry edge.
        bus.req_data = {8'h13, 8'h12, 8'h11, 8'h55};
        bus.req      = 4'b0001;
        wait_ack();
        check_eq("to_ack", 32'(bus.ack), 32'b0001);
        bus.req = '0;
        @(posedge clk);
        repeat (63) @(posedge clk);
        @(negedge clk);
        check_eq("to_early", 32'(bus.rsp_valid), 32'd0);
        @(negedge clk);
        check_eq("to_rspv", 32'(bus.rsp_valid), 32'b0001);
        check_eq("to_err", 32'(bus.rsp_err), 32'd1);
        check_eq("to_data", 32'(bus.rsp_data), 32'd0);
        @(negedge clk);
        check_eq("to_idle", 32'(bus.busy), 32'd0);
        bus.req = 4'b0100;
        serve(2, 8'h12, 8'h66, 4);

        // Done coincides with the last timer cycle: done wins.
        bus.req = 4'b1000;
        wait_ack();
        check_eq("co_ack", 32'(bus.ack), 32'b1000);
        bus.req = '0;
        @(posedge clk);
        repeat (63) @(posedge clk);
        @(negedge clk);
        bus.spi_done    = 1'b1;
        bus.spi_rx_data = 8'hC7;
        @(negedge clk);
        bus.spi_done = 1'b0;
        check_eq("co_rspv", 32'(bus.rsp_valid), 32'b1000);
        check_eq("co_err", 32'(bus.rsp_err), 32'd0);
        check_eq("co_data", 32'(bus.rsp_data), 32'hC7);
        @(negedge clk);

        // Reset mid-WAIT, then pending req 0010 first; stale done ignored.
        bus.req_data = {8'h13, 8'h77, 8'h5A, 8'h55};
        bus.req      = 4'b0100;
        wait_ack();
        check_eq("mr_ack", 32'(bus.ack), 32'b0100);
        bus.req = '0;
        repeat (5) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check_eq("mr_busy_gnt", 32'({bus.busy, bus.gnt_id}), 32'd0);
        check_eq("mr_tx_data", 32'({bus.spi_tx_data, bus.rsp_data}), 32'd0);
        check_eq("mr_pulses", 32'({bus.ack, bus.rsp_valid, bus.spi_start, bus.rsp_err}), 32'd0);
        bus.req = 4'b0010;
        @(negedge clk);
        reset           = 1'b1;
        bus.spi_done    = 1'b1;
        bus.spi_rx_data = 8'h99;
        @(negedge clk);
        bus.spi_done = 1'b0;
        check_eq("mr_ack2", 32'(bus.ack), 32'b0010);
        check_eq("mr_gnt2", 32'(bus.gnt_id), 32'd1);
        bus.req = '0;
        seen = bus.rsp_valid;
        repeat (5) begin
            @(negedge clk);
            seen = seen | bus.rsp_valid;
        end
        check_eq("mr_stale", 32'(seen), 32'd0);
        bus.spi_done    = 1'b1;
        bus.spi_rx_data = 8'h42;
        @(negedge clk);
        bus.spi_done = 1'b0;
        check_eq("mr_rspv", 32'(bus.rsp_valid), 32'b0010);
        check_eq("mr_rspd", 32'(bus.rsp_data), 32'h42);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/spi_req_arbiter.md
Name: spi_req_arbiter

Overview:
- Shares one spi_master byte engine between N_REQ requesters (sensor, flash and config engines), using round-robin arbitration.
- For each granted requester it latches the TX byte, pulses the master's start, and waits for done.
- It then returns the RX byte to the granted requester.
- A watchdog aborts a transfer whose done never arrives, so a hung master cannot block the bus.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- DATA_W, 8, transfer byte width; must match the SPI master
- TIMEOUT, 64, max cycles in WAIT before abort; 0 disables the watchdog
- IDX_W, $clog2(N_REQ), grant index width (derived, not overridden)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- req  in  N_REQ  level request per requester
- req_data  in  N_REQ*DATA_W  TX byte per requester; slice i = [i*DATA_W +: DATA_W]
- ack  out  N_REQ  one-hot, 1-cycle pulse: request accepted and req_data captured
- rsp_valid  out  N_REQ  one-hot, 1-cycle pulse: response ready
- rsp_data  out  DATA_W  RX byte; valid only while rsp_valid != 0
- rsp_err  out  1  timeout flag; qualified by rsp_valid
- busy  out  1  high in every state except IDLE
- gnt_id  out  IDX_W  index of the current or last granted requester
- spi_start  out  1  1-cycle start pulse to the SPI master
- spi_tx_data  out  DATA_W  byte to the master; held stable from ISSUE until the next grant
- spi_done  in  1  done pulse from the master
- spi_rx_data  in  DATA_W  byte from the master; sampled only when spi_done=1

Behaviour:
- Reset (async, active low):
  - State = IDLE.
  - ack, rsp_valid, rsp_data, rsp_err, busy, spi_start, spi_tx_data, gnt_id all 0.
  - Round-robin pointer last = N_REQ-1, so requester 0 has top priority first.
  - Timer = 0.
  - Reset mid-transfer drops the transaction silently: no rsp_valid and no error.
- All outputs are registered.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If |req, select the first i with req[i]=1, searching (last+1) mod N_REQ upward with wrap.
  - Latch gnt_id=i and spi_tx_data=req_data slice i, then go to ISSUE.
  - If no request, stay in IDLE.
- ISSUE (exactly 1 cycle):
  - spi_start=1, ack[gnt_id]=1, busy=1, timer cleared; go to WAIT.
  - spi_done during ISSUE is ignored.
- WAIT:
  - On spi_done=1: capture spi_rx_data into rsp_data, rsp_err=0, go to RESP.
  - Otherwise, with TIMEOUT != 0, timer increments each cycle. When timer == TIMEOUT-1 and spi_done=0: rsp_data=0, rsp_err=1, go to RESP.
  - If spi_done and timeout coincide, done wins (rsp_err=0).
  - TIMEOUT=0: wait indefinitely.
- RESP (exactly 1 cycle):
  - rsp_valid[gnt_id]=1; last=gnt_id; go to IDLE.
  - rsp_data and rsp_err hold until the next RESP.
- Latency:
  - req high in IDLE at edge k: ack and spi_start high in cycle k+1.
  - spi_done at edge m: rsp_valid in cycle m+1.
  - Minimum 1 idle cycle between grants.
- Requester obligation:
  - Drop req within the ack cycle or by its next edge; after that, req still high is treated as a new request.
  - req_data only needs to be stable in the arbitration cycle.
- Simultaneous requests are resolved purely by the rotating pointer. No requester is starved: worst-case wait is N_REQ-1 transactions.
- req changes during ISSUE/WAIT/RESP are ignored until IDLE.
- spi_done seen in IDLE or RESP is ignored: no state change, no response.

Test Plan:
- Single request: reset, req=4'b0100, data slice2=8'hA5; master returns 8'h3C after 20 cycles -> ack=4'b0100 one cycle, spi_start one cycle, spi_tx_data=8'hA5, rsp_valid=4'b0100 one cycle with rsp_data=8'h3C, rsp_err=0, busy low afterward.
- All four requesters from reset with req=4'b1111, each dropping req on its ack -> grants in order 0,1,2,3; exactly 4 spi_start pulses; each rsp_valid is routed to the matching requester.
- Fairness: after requester 2 is served, req=4'b1010 -> grant 3, then 1 (wrap); requester 1 re-asserting continuously never beats a pending requester 3.
- Timeout with TIMEOUT=64 and spi_done never asserted -> rsp_valid pulse 64 cycles after the WAIT entry edge with rsp_err=1, rsp_data=8'h00; the next request is then served normally.
- spi_done in the same cycle the timer hits TIMEOUT-1 -> rsp_err=0, rsp_data = master byte.
- Reset asserted mid-WAIT -> all outputs 0 immediately; after release, a pending req=4'b0010 is granted first; a stale spi_done right after reset produces no rsp_valid.
